// File: rtl/cpu_controller.sv
// Multicycle Moore control FSM for the 16-bit datapath: owns the instruction
// register, sequences fetch/decode/execute and drives all datapath controls.
module cpu_controller #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned REG_ADD = 4,
  parameter int unsigned IMM     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   mem_data,
  output logic               pcen,
  output logic               pc_s,
  output logic               mem_s,
  output logic               memwrite,
  output logic               regwrite,
  output logic [1:0]         wd_s,
  output logic [1:0]         alua_s,
  output logic               alub_s,
  output logic               signext_sign,
  output logic [2:0]         alucont,
  output logic [IMM-1:0]     imm,
  output logic [REG_ADD-1:0] rsrc_addr,
  output logic [REG_ADD-1:0] rdest_addr,
  output logic [REG_ADD-1:0] wa,
  output logic               illegal,
  output logic [3:0]         state
);

  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned EXT_LSB  = 4;
  localparam int unsigned RDST_LSB = 8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_LATCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_ALU_WB  = 4'd3,
    S_LD_ADDR = 4'd4,
    S_LD_WB   = 4'd5,
    S_STORE   = 4'd6,
    S_JUMP    = 4'd7,
    S_ILLEGAL = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    K_RALU, K_IALU, K_MOV, K_MOVI, K_LOAD, K_STOR, K_JUMP, K_ILL
  } kind_t;

  // Instruction class from op/ext fields.
  function automatic kind_t kind_of(input logic [WIDTH-1:0] ir);
    logic [3:0] op;
    logic [3:0] ext;
    kind_t      k;
    op  = ir[OP_LSB +: 4];
    ext = ir[EXT_LSB +: 4];
    k   = K_ILL;
    case (op)
      4'b0000: begin
        case (ext)
          4'b0101, 4'b1001, 4'b0001, 4'b0010, 4'b0011: k = K_RALU;
          4'b1101: k = K_MOV;
          default: k = K_ILL;
        endcase
      end
      4'b0101, 4'b1001, 4'b0001, 4'b0010, 4'b0011: k = K_IALU;
      4'b1101: k = K_MOVI;
      4'b0100: begin
        case (ext)
          4'b0000: k = K_LOAD;
          4'b0100: k = K_STOR;
          4'b1100: k = K_JUMP;
          default: k = K_ILL;
        endcase
      end
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  // ALU operation from the 4-bit function code (ext for R-type, op for immediates).
  function automatic logic [2:0] alu_of(input logic [3:0] code);
    logic [2:0] a;
    case (code)
      4'b1001: a = ALU_SUB;
      4'b0001: a = ALU_AND;
      4'b0010: a = ALU_OR;
      4'b0011: a = ALU_XOR;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   instr_q, instr_n;
  kind_t              kind_n;

  logic       pcen_n, pc_s_n, mem_s_n, memwrite_n, regwrite_n;
  logic [1:0] wd_s_n, alua_s_n;
  logic       alub_s_n, signext_n, illegal_n;
  logic [2:0] alucont_n;

  // Next state and instruction register.
  always_comb begin
    state_n = S_FETCH;
    instr_n = instr_q;
    case (state_q)
      S_FETCH:   state_n = S_LATCH;
      S_LATCH: begin
        state_n = S_DECODE;
        instr_n = mem_data;
      end
      S_DECODE: begin
        case (kind_of(instr_q))
          K_RALU, K_IALU, K_MOV, K_MOVI: state_n = S_ALU_WB;
          K_LOAD:  state_n = S_LD_ADDR;
          K_STOR:  state_n = S_STORE;
          K_JUMP:  state_n = S_JUMP;
          default: state_n = S_ILLEGAL;
        endcase
      end
      S_LD_ADDR: state_n = S_LD_WB;
      default:   state_n = S_FETCH;
    endcase
  end

  // Moore decode of the upcoming state so every control output is a flop.
  always_comb begin
    pcen_n     = 1'b0;
    pc_s_n     = 1'b0;
    mem_s_n    = 1'b0;
    memwrite_n = 1'b0;
    regwrite_n = 1'b0;
    wd_s_n     = 2'b00;
    alua_s_n   = 2'b00;
    alub_s_n   = 1'b0;
    signext_n  = 1'b0;
    alucont_n  = ALU_ADD;
    illegal_n  = 1'b0;
    kind_n     = kind_of(instr_n);
    case (state_n)
      S_FETCH: mem_s_n = 1'b1;
      S_LATCH: begin
        alua_s_n  = 2'b01;
        alub_s_n  = 1'b1;
        alucont_n = ALU_ADD;
        pc_s_n    = 1'b1;
        pcen_n    = 1'b1;
      end
      S_ALU_WB: begin
        regwrite_n = 1'b1;
        case (kind_n)
          K_RALU: begin
            alua_s_n  = 2'b00;
            wd_s_n    = 2'b11;
            alucont_n = alu_of(instr_n[EXT_LSB +: 4]);
          end
          K_IALU: begin
            alua_s_n  = 2'b10;
            wd_s_n    = 2'b11;
            alucont_n = alu_of(instr_n[OP_LSB +: 4]);
            signext_n = (instr_n[OP_LSB +: 4] == 4'b0101) ||
                        (instr_n[OP_LSB +: 4] == 4'b1001);
          end
          K_MOV:   wd_s_n = 2'b01;
          default: wd_s_n = 2'b00;
        endcase
      end
      S_LD_WB: begin
        regwrite_n = 1'b1;
        wd_s_n     = 2'b10;
      end
      S_STORE:   memwrite_n = 1'b1;
      S_JUMP:    pcen_n     = 1'b1;
      S_ILLEGAL: illegal_n  = 1'b1;
      default: ;
    endcase
  end

  // State, instruction register and registered controls; reset drops enables at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      instr_q      <= '0;
      pcen         <= 1'b0;
      pc_s         <= 1'b0;
      mem_s        <= 1'b1;
      memwrite     <= 1'b0;
      regwrite     <= 1'b0;
      wd_s         <= 2'b00;
      alua_s       <= 2'b00;
      alub_s       <= 1'b0;
      signext_sign <= 1'b0;
      alucont      <= ALU_ADD;
      illegal      <= 1'b0;
    end else begin
      state_q      <= state_n;
      instr_q      <= instr_n;
      pcen         <= pcen_n;
      pc_s         <= pc_s_n;
      mem_s        <= mem_s_n;
      memwrite     <= memwrite_n;
      regwrite     <= regwrite_n;
      wd_s         <= wd_s_n;
      alua_s       <= alua_s_n;
      alub_s       <= alub_s_n;
      signext_sign <= signext_n;
      alucont      <= alucont_n;
      illegal      <= illegal_n;
    end
  end

  assign state      = state_q;
  assign imm        = instr_q[IMM-1:0];
  assign rsrc_addr  = instr_q[REG_ADD-1:0];
  assign rdest_addr = instr_q[RDST_LSB +: REG_ADD];
  assign wa         = instr_q[RDST_LSB +: REG_ADD];

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: per-cycle expected control vectors are
// queued when an instruction is presented and popped each cycle.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_data;
  logic        pcen, pc_s, mem_s, memwrite, regwrite, alub_s, signext_sign, illegal;
  logic [1:0]  wd_s, alua_s;
  logic [2:0]  alucont;
  logic [7:0]  imm;
  logic [3:0]  rsrc_addr, rdest_addr, wa, state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, pc_s, mem_s, memwrite, regwrite;
    logic [1:0] wd_s, alua_s;
    logic       alub_s, sx;
    logic [2:0] alu;
    logic       ill;
  } vec_t;

  vec_t exp_q[$];

  cpu_controller dut (
    .clk(clk), .reset(reset), .mem_data(mem_data),
    .pcen(pcen), .pc_s(pc_s), .mem_s(mem_s), .memwrite(memwrite),
    .regwrite(regwrite), .wd_s(wd_s), .alua_s(alua_s), .alub_s(alub_s),
    .signext_sign(signext_sign), .alucont(alucont), .imm(imm),
    .rsrc_addr(rsrc_addr), .rdest_addr(rdest_addr), .wa(wa),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t dut_vec();
    vec_t v;
    v = '{st: state, pcen: pcen, pc_s: pc_s, mem_s: mem_s, memwrite: memwrite,
          regwrite: regwrite, wd_s: wd_s, alua_s: alua_s, alub_s: alub_s,
          sx: signext_sign, alu: alucont, ill: illegal};
    return v;
  endfunction

  function automatic logic [2:0] alu_enc(input logic [3:0] c);
    if (c == 4'h9) return 3'b001;
    if (c == 4'h1) return 3'b010;
    if (c == 4'h2) return 3'b011;
    if (c == 4'h3) return 3'b100;
    return 3'b000;
  endfunction

  // Reference control table, indexed by state and the latched instruction.
  function automatic vec_t exp_vec(input int st, input logic [15:0] ir);
    vec_t v;
    logic [3:0] op, ext;
    op  = ir[15:12];
    ext = ir[7:4];
    v = '0;
    v.st = 4'(st);
    case (st)
      0: v.mem_s = 1'b1;
      1: begin v.alua_s = 2'b01; v.alub_s = 1'b1; v.pc_s = 1'b1; v.pcen = 1'b1; end
      3: begin
        v.regwrite = 1'b1;
        if (op == 4'h0 && ext == 4'hD) v.wd_s = 2'b01;
        else if (op == 4'hD) v.wd_s = 2'b00;
        else if (op == 4'h0) begin v.wd_s = 2'b11; v.alu = alu_enc(ext); end
        else begin
          v.wd_s = 2'b11; v.alua_s = 2'b10; v.alu = alu_enc(op);
          v.sx = (op == 4'h5 || op == 4'h9);
        end
      end
      5: begin v.regwrite = 1'b1; v.wd_s = 2'b10; end
      6: v.memwrite = 1'b1;
      7: v.pcen = 1'b1;
      8: v.ill = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  // State after DECODE for a given instruction word.
  function automatic int exec_state(input logic [15:0] ir);
    logic [3:0] op, ext;
    op  = ir[15:12];
    ext = ir[7:4];
    if (op == 4'h0)
      return (ext inside {4'h5, 4'h9, 4'h1, 4'h2, 4'h3, 4'hD}) ? 3 : 8;
    if (op inside {4'h5, 4'h9, 4'h1, 4'h2, 4'h3, 4'hD}) return 3;
    if (op == 4'h4) begin
      if (ext == 4'h0) return 4;
      if (ext == 4'h4) return 6;
      if (ext == 4'hC) return 7;
    end
    return 8;
  endfunction

  task automatic run_instr(input logic [15:0] ir);
    vec_t e;
    int   x;
    mem_data = ir;
    x = exec_state(ir);
    exp_q.push_back(exp_vec(0, 16'h0));
    exp_q.push_back(exp_vec(1, ir));
    exp_q.push_back(exp_vec(2, ir));
    exp_q.push_back(exp_vec(x, ir));
    if (x == 4) exp_q.push_back(exp_vec(5, ir));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%h st%0d ctl", ir, e.st), 32'(dut_vec()), 32'(e));
      if (e.st == 4'd2)
        check($sformatf("%h fields", ir), {16'h0, imm, rsrc_addr, rdest_addr},
              {16'h0, ir[7:0], ir[3:0], ir[11:8]});
      if (e.st == 4'd2)
        check($sformatf("%h wa", ir), 32'(wa), 32'(ir[11:8]));
    end
  endtask

  initial begin
    logic [15:0] prog [16] = '{16'h0351, 16'h0291, 16'h0612, 16'h0723,
                               16'h0834, 16'h0ED3, 16'h59FF, 16'h19FF,
                               16'h9A80, 16'h2B0F, 16'h3C55, 16'hD7AB,
                               16'h4204, 16'h4AC5, 16'h0F00, 16'h4010};
    reset    = 1'b0;
    mem_data = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset c%0d ctl", i), 32'(dut_vec()), 32'(exp_vec(0, 16'h0)));
      check($sformatf("reset c%0d instr", i), {20'h0, imm, rsrc_addr}, 32'h0);
    end
    @(posedge clk);
    #1 reset = 1'b1;

    foreach (prog[i]) run_instr(prog[i]);

    // Store interrupted by reset: memwrite and state must drop immediately.
    run_instr(16'h4647);
    #1 reset = 1'b0;
    #1;
    check("store abort memwrite", 32'(memwrite), 32'h0);
    check("store abort state", 32'(state), 32'h0);
    check("store abort instr", {16'h0, imm, rsrc_addr, rdest_addr}, 32'h0);
    check("store abort ctl", 32'(dut_vec()), 32'(exp_vec(0, 16'h0)));
    @(posedge clk);
    #1 reset = 1'b1;

    run_instr(16'h4204);
    run_instr(16'hF000);
    @(negedge clk);
    check("post illegal fetch", 32'(dut_vec()), 32'(exp_vec(0, 16'h0)));
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
